// File: rtl/cle_stat.sv
// cle_stat: per-label area and bounding-box statistics over a 32x32 label SRAM.
// Sequence: clear the flop table, scan all 1024 addresses (1-cycle read
// latency), then stream one record per non-empty label over valid/ready.
// Optional feature macro: CLE_STAT_BBOX_EN enables bounding-box tracking and
// output. Without it stat_xmin/xmax/ymin/ymax are tied to 0.
//
// Handshake: a record transfers on a rising edge where stat_valid && stat_ready.
// While stat_valid is high and stat_ready is low, every stat_* output holds.
// stat_valid never drops without a transfer; the next record may be presented
// in the cycle right after a transfer.
module cle_stat #(
  parameter int MAX_LABEL = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  sram_q,
  output logic [9:0]  sram_a,
  output logic        busy,
  output logic        stat_valid,
  input  logic        stat_ready,
  output logic [7:0]  stat_label,
  output logic [10:0] stat_area,
  output logic [4:0]  stat_xmin,
  output logic [4:0]  stat_xmax,
  output logic [4:0]  stat_ymin,
  output logic [4:0]  stat_ymax,
  output logic        ovf,
  output logic        done,
  output logic [2:0]  dbg_state
);

  localparam int         TW       = $clog2(MAX_LABEL);
  localparam logic [7:0] LAST_IDX = 8'(MAX_LABEL - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_SCAN  = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state_q;
  logic [7:0]  idx_q;      // clear index in CLEAR, emit index in EMIT
  logic [10:0] cnt_q;      // scan cycle 0..1024
  logic [9:0]  sram_a_q;
  logic        busy_q;
  logic        valid_q;
  logic        ovf_q;
  logic        done_q;
  logic [7:0]  label_q;
  logic [10:0] area_q;

  logic [10:0] tab_area [MAX_LABEL];

  // Read-side decode: in scan cycle k>0, sram_q holds the label at address k-1.
  logic          rd_vld;
  logic [9:0]    rd_addr;
  logic [4:0]    rd_x;
  logic [4:0]    rd_y;
  logic          in_range;
  logic          hit;
  logic          oob;
  logic [TW-1:0] hit_idx;
  logic [10:0]   upd_area;

  assign rd_vld   = (state_q == S_SCAN) && (cnt_q != 11'd0);
  assign rd_addr  = cnt_q[9:0] - 10'd1;
  assign rd_x     = rd_addr[4:0];
  assign rd_y     = rd_addr[9:5];
  assign in_range = ({1'b0, sram_q} < 9'(MAX_LABEL));
  assign hit      = rd_vld && (sram_q != 8'd0) && in_range;
  assign oob      = rd_vld && !in_range;
  assign hit_idx  = sram_q[TW-1:0];
  assign upd_area = tab_area[hit_idx] + 11'd1;

  // Record load control. The first record (label 1) is loaded on the same
  // edge as the final table update, so that update is bypassed into it.
  logic          scan_end;
  logic          emit_adv;
  logic          emit_last;
  logic          ld_en;
  logic [7:0]    src_label;
  logic [TW-1:0] src_idx;
  logic          src_byp;
  logic [10:0]   ld_area;

  assign scan_end  = (state_q == S_SCAN) && (cnt_q == 11'd1024);
  assign emit_adv  = (state_q == S_EMIT) && (!valid_q || stat_ready);
  assign emit_last = (idx_q == LAST_IDX);
  assign ld_en     = scan_end || (emit_adv && !emit_last);
  assign src_label = (state_q == S_SCAN) ? 8'd1 : (idx_q + 8'd1);
  assign src_idx   = src_label[TW-1:0];
  assign src_byp   = (state_q == S_SCAN) && hit && (hit_idx == TW'(1));
  assign ld_area   = src_byp ? upd_area : tab_area[src_idx];

  // Area table: cleared one entry per cycle, then one update per scan cycle.
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) begin
      tab_area[idx_q[TW-1:0]] <= 11'd0;
    end else if (hit) begin
      tab_area[hit_idx] <= upd_area;
    end
  end

  // Main control FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= 8'd0;
      cnt_q    <= 11'd0;
      sram_a_q <= 10'd0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_CLEAR;
            idx_q   <= 8'd0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (emit_last) begin
            state_q  <= S_SCAN;
            cnt_q    <= 11'd0;
            sram_a_q <= 10'd0;
          end else begin
            idx_q <= idx_q + 8'd1;
          end
        end
        S_SCAN: begin
          if (oob) begin
            ovf_q <= 1'b1;
          end
          if (scan_end) begin
            state_q  <= S_EMIT;
            idx_q    <= 8'd1;
            sram_a_q <= 10'd0;
            valid_q  <= (ld_area != 11'd0);
          end else begin
            cnt_q    <= cnt_q + 11'd1;
            // address 1023 + 1 wraps to 0, which is the idle value
            sram_a_q <= cnt_q[9:0] + 10'd1;
          end
        end
        S_EMIT: begin
          if (emit_adv) begin
            if (emit_last) begin
              state_q <= S_DONE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q   <= idx_q + 8'd1;
              valid_q <= (ld_area != 11'd0);
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Record label/area registers, loaded whenever the emit index moves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      label_q <= 8'd0;
      area_q  <= 11'd0;
    end else if (ld_en) begin
      label_q <= src_label;
      area_q  <= ld_area;
    end
  end

`ifdef CLE_STAT_BBOX_EN
  logic [4:0] tab_xmin [MAX_LABEL];
  logic [4:0] tab_xmax [MAX_LABEL];
  logic [4:0] tab_ymin [MAX_LABEL];
  logic [4:0] tab_ymax [MAX_LABEL];
  logic [4:0] upd_xmin, upd_xmax, upd_ymin, upd_ymax;
  logic [4:0] ld_xmin, ld_xmax, ld_ymin, ld_ymax;
  logic [4:0] xmin_q, xmax_q, ymin_q, ymax_q;

  assign upd_xmin = (rd_x < tab_xmin[hit_idx]) ? rd_x : tab_xmin[hit_idx];
  assign upd_xmax = (rd_x > tab_xmax[hit_idx]) ? rd_x : tab_xmax[hit_idx];
  assign upd_ymin = (rd_y < tab_ymin[hit_idx]) ? rd_y : tab_ymin[hit_idx];
  assign upd_ymax = (rd_y > tab_ymax[hit_idx]) ? rd_y : tab_ymax[hit_idx];
  assign ld_xmin  = src_byp ? upd_xmin : tab_xmin[src_idx];
  assign ld_xmax  = src_byp ? upd_xmax : tab_xmax[src_idx];
  assign ld_ymin  = src_byp ? upd_ymin : tab_ymin[src_idx];
  assign ld_ymax  = src_byp ? upd_ymax : tab_ymax[src_idx];

  // Bounding-box table: cleared to an empty box, then widened per hit.
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) begin
      tab_xmin[idx_q[TW-1:0]] <= 5'd31;
      tab_xmax[idx_q[TW-1:0]] <= 5'd0;
      tab_ymin[idx_q[TW-1:0]] <= 5'd31;
      tab_ymax[idx_q[TW-1:0]] <= 5'd0;
    end else if (hit) begin
      tab_xmin[hit_idx] <= upd_xmin;
      tab_xmax[hit_idx] <= upd_xmax;
      tab_ymin[hit_idx] <= upd_ymin;
      tab_ymax[hit_idx] <= upd_ymax;
    end
  end

  // Bounding-box record registers, loaded alongside label/area.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xmin_q <= 5'd0;
      xmax_q <= 5'd0;
      ymin_q <= 5'd0;
      ymax_q <= 5'd0;
    end else if (ld_en) begin
      xmin_q <= ld_xmin;
      xmax_q <= ld_xmax;
      ymin_q <= ld_ymin;
      ymax_q <= ld_ymax;
    end
  end

  assign stat_xmin = xmin_q;
  assign stat_xmax = xmax_q;
  assign stat_ymin = ymin_q;
  assign stat_ymax = ymax_q;
`else
  assign stat_xmin = 5'd0;
  assign stat_xmax = 5'd0;
  assign stat_ymin = 5'd0;
  assign stat_ymax = 5'd0;
`endif

  assign sram_a     = sram_a_q;
  assign busy       = busy_q;
  assign stat_valid = valid_q;
  assign stat_label = label_q;
  assign stat_area  = area_q;
  assign ovf        = ovf_q;
  assign done       = done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_cle_stat.sv
// Bench for cle_stat: a table of image/backpressure runs checked through an
// expected-record queue, plus hand-written reset and held-start sequences.
module tb_cle_stat;

  localparam int MAXL     = 64;
  localparam int RW       = 39;
  localparam int BASE_LAT = 1153;
  localparam int BUDGET   = 3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stat_ready;
  logic [7:0]  sram_q;
  logic [9:0]  sram_a;
  logic        busy;
  logic        stat_valid;
  logic [7:0]  stat_label;
  logic [10:0] stat_area;
  logic [4:0]  stat_xmin, stat_xmax, stat_ymin, stat_ymax;
  logic        ovf;
  logic        done;
  logic [2:0]  dbg_state;

  logic [7:0]    mem [1024];
  logic [RW-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int   kind;
    int   mode;   // 0: ready high, 1: 10-cycle stall on first record, 2: random
    int   lat;
    logic ovf;
    int   nrec;   // -1: count comes from the model only
  } vec_t;
  vec_t vecs [8];

  cle_stat #(.MAX_LABEL(MAXL)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .sram_q     (sram_q),
    .sram_a     (sram_a),
    .busy       (busy),
    .stat_valid (stat_valid),
    .stat_ready (stat_ready),
    .stat_label (stat_label),
    .stat_area  (stat_area),
    .stat_xmin  (stat_xmin),
    .stat_xmax  (stat_xmax),
    .stat_ymin  (stat_ymin),
    .stat_ymax  (stat_ymax),
    .ovf        (ovf),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // clock, cycle counter and 1-cycle-latency SRAM model
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) sram_q <= mem[sram_a];

  function automatic logic [RW-1:0] cur_rec();
    return {stat_label, stat_area, stat_xmin, stat_xmax, stat_ymin, stat_ymax};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {sram_a, busy, stat_valid, stat_label, stat_area, stat_xmin,
                 stat_xmax, stat_ymin, stat_ymax, ovf, done}, 64'd0);
  endtask

  task automatic load_image(input int kind);
    for (int a = 0; a < 1024; a++) mem[a] = 8'd0;
    case (kind)
      1: mem[10'h0A3] = 8'd1;
      2, 5: begin
        for (int y = 0; y < 3; y++)
          for (int x = 10; x < 14; x++) mem[y*32 + x] = 8'd2;
        for (int x = 0; x < 32; x++) mem[31*32 + x] = 8'd7;
        if (kind == 5) mem[300] = 8'd70;
      end
      3: mem[300] = 8'd70;
      4: begin
        for (int a = 0; a < 1024; a++)
          if ($urandom_range(0, 7) == 0) mem[a] = 8'($urandom_range(1, MAXL - 1));
        mem[0]    = 8'(MAXL - 1);
        mem[1023] = 8'd1;
      end
      default: ;
    endcase
  endtask

  // reference model: push one record per non-empty label in label order
  task automatic push_expected(output int n);
    n = 0;
    for (int l = 1; l < MAXL; l++) begin
      int area = 0;
      int x0 = 31, x1 = 0, y0 = 31, y1 = 0;
      for (int a = 0; a < 1024; a++) begin
        if (mem[a] == 8'(l)) begin
          area++;
          if (a % 32 < x0) x0 = a % 32;
          if (a % 32 > x1) x1 = a % 32;
          if (a / 32 < y0) y0 = a / 32;
          if (a / 32 > y1) y1 = a / 32;
        end
      end
      if (area > 0) begin
        n++;
`ifdef CLE_STAT_BBOX_EN
        exp_q.push_back({8'(l), 11'(area), 5'(x0), 5'(x1), 5'(y0), 5'(y1)});
`else
        exp_q.push_back({8'(l), 11'(area), 20'd0});
`endif
      end
    end
  endtask

  // pulse start for one edge; c0 is the cycle count at the sampling edge
  task automatic start_run(output int c0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c0 = cyc;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_image(input vec_t v, input string tag);
    int   nexp, c0, lat;
    int   stalls  = 0;
    int   bp_left = 10;
    int   seen    = 0;
    logic held    = 1'b0;
    logic done_seen = 1'b0;
    logic [RW-1:0] held_rec;
    logic [RW-1:0] exp;
    lat = 0;
    load_image(v.kind);
    push_expected(nexp);
    stat_ready = 1'b1;
    start_run(c0);
    check({tag, "_ovf_cleared"}, ovf, 0);
    check({tag, "_busy_start"}, busy, 1);
    for (int n = 0; n < BUDGET && !done_seen; n++) begin
      if (n > 0) @(negedge clk);
      if (held) check({tag, "_stall_hold"}, {stat_valid, cur_rec()}, {1'b1, held_rec});
      held = 1'b0;
      if (done) begin
        done_seen = 1'b1;
        lat = cyc - c0 + 1;
        start = 1'b0;
      end else begin
        case (v.mode)
          1: begin
            if (stat_valid && bp_left > 0) begin
              stat_ready = 1'b0;
              bp_left--;
            end else stat_ready = 1'b1;
          end
          2: begin
            stat_ready = ($urandom_range(0, 3) != 0);
            start      = ($urandom_range(0, 7) == 0);
          end
          default: stat_ready = 1'b1;
        endcase
        if (stat_valid) begin
          if (stat_ready) begin
            seen++;
            check({tag, "_queue_nonempty"}, exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
              exp = exp_q.pop_front();
              check({tag, "_record"}, cur_rec(), exp);
            end
          end else begin
            stalls++;
            held     = 1'b1;
            held_rec = cur_rec();
          end
        end
      end
    end
    start = 1'b0;
    stat_ready = 1'b1;
    check({tag, "_done_seen"}, done_seen, 1);
    if (done_seen) begin
      check({tag, "_latency"}, lat, v.lat + ((v.mode == 2) ? stalls : 0));
      check({tag, "_ovf_at_done"}, ovf, v.ovf);
      check({tag, "_busy_at_done"}, busy, 1);
      check({tag, "_sram_a_idle"}, sram_a, 0);
    end else begin
      $display("FAIL %s_timeout: state %0d, no done within %0d cycles", tag, dbg_state, BUDGET);
    end
    check({tag, "_records_missing"}, exp_q.size(), 0);
    if (v.nrec >= 0) check({tag, "_record_count"}, seen, v.nrec);
    exp_q.delete();
    @(negedge clk);
    check({tag, "_idle_after_done"}, {done, busy, stat_valid}, 0);
    if (!done_seen) pulse_reset();
  endtask

  initial begin
    int   c0, c1, n_dummy;
    logic found;
    vecs[0] = '{kind: 0, mode: 0, lat: BASE_LAT,      ovf: 1'b0, nrec: 0};
    vecs[1] = '{kind: 1, mode: 0, lat: BASE_LAT,      ovf: 1'b0, nrec: 1};
    vecs[2] = '{kind: 2, mode: 0, lat: BASE_LAT,      ovf: 1'b0, nrec: 2};
    vecs[3] = '{kind: 2, mode: 1, lat: BASE_LAT + 10, ovf: 1'b0, nrec: 2};
    vecs[4] = '{kind: 3, mode: 0, lat: BASE_LAT,      ovf: 1'b1, nrec: 0};
    vecs[5] = '{kind: 4, mode: 2, lat: BASE_LAT,      ovf: 1'b0, nrec: -1};
    vecs[6] = '{kind: 4, mode: 0, lat: BASE_LAT,      ovf: 1'b0, nrec: -1};
    vecs[7] = '{kind: 5, mode: 0, lat: BASE_LAT,      ovf: 1'b1, nrec: 2};

    reset = 1'b0;
    start = 1'b0;
    stat_ready = 1'b1;
    for (int a = 0; a < 1024; a++) mem[a] = 8'd0;
    #2 reset = 1'b1;
    #1 check_reset_outputs("reset_initial");
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_held");
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_image(vecs[i], $sformatf("vec%0d", i));

    // reset pulsed mid-scan at address 500, then the same image again
    load_image(5);
    start_run(c0);
    found = 1'b0;
    for (int n = 0; n < BUDGET && !found; n++) begin
      @(negedge clk);
      if (sram_a == 10'd500) found = 1'b1;
    end
    check("reached_addr_500", found, 1);
    check("ovf_before_reset", ovf, 1);
    reset = 1'b1;
    #1 check_reset_outputs("reset_mid_scan");
    @(negedge clk);
    check_reset_outputs("reset_mid_scan_held");
    reset = 1'b0;
    run_image(vecs[7], "rerun");

    // start held high: a new run begins right after DONE -> IDLE
    load_image(0);
    push_expected(n_dummy);
    check("held_start_no_records", n_dummy, 0);
    @(negedge clk);
    start = 1'b1;
    found = 1'b0;
    for (int n = 0; n < BUDGET && !found; n++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    check("held_start_first_done", found, 1);
    @(negedge clk);
    check("held_start_idle_gap", busy, 0);
    @(negedge clk);
    check("held_start_restart", busy, 1);
    c1 = cyc;
    start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < BUDGET && !found; n++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    check("held_start_second_done", found, 1);
    check("held_start_latency", cyc - c1 + 1, BASE_LAT);
    check("held_start_no_valid", stat_valid, 0);
    exp_q.delete();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cle_stat.md
# cle_stat

Component statistics engine placed directly downstream of the component labeling engine. After labeling finishes, it scans the 1024-byte label SRAM of the 32x32 image and accumulates, per label, the pixel count (area) and the bounding box. It then streams one record per non-empty label over a valid/ready interface. It shares the label SRAM read port with the labeling engine and only drives that port while busy.

## Interface
- `MAX_LABEL`, default 64: number of label table entries. Labels 1..MAX_LABEL-1 are tracked; label 0 is background. Legal range 2..256.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: begin a run; connect to the labeling engine's `finish`. Level-sampled in IDLE.
- `sram_q` in 8: label SRAM read data, valid one cycle after `sram_a`.
- `sram_a` out 10: label SRAM address; pixel x = a[4:0], y = a[9:5].
- `busy` out 1: high from the cycle after `start` is accepted through the DONE state.
- `stat_valid` out 1: record available.
- `stat_ready` in 1: consumer accepts the record.
- `stat_label` out 8: label value.
- `stat_area` out 11: pixel count, 1..1024.
- `stat_xmin`, `stat_xmax`, `stat_ymin`, `stat_ymax` out 5 each: inclusive bounding box.
- `ovf` out 1: sticky per run; set when a label >= MAX_LABEL is read.
- `done` out 1: one-cycle pulse at the end of the run.

## Operation
- States: IDLE, CLEAR, SCAN, EMIT, DONE.
- IDLE: when `start`=1, go to CLEAR and clear `ovf`.
- CLEAR: MAX_LABEL cycles, one table entry per cycle.
  - Cleared entry: area=0, xmin=ymin=31, xmax=ymax=0.
- SCAN: 1025 cycles.
  - Cycle k (k=0..1023) drives `sram_a`=k.
  - Cycle k+1 (k=0..1023) captures `sram_q` for address k and updates the table.
  - For a label L with 0 < L < MAX_LABEL: area += 1; x/y min/max update with the x/y of address k.
  - L=0: no update. L >= MAX_LABEL: no update, set `ovf`.
  - The table is flop-based, so back-to-back hits on the same label need no forwarding. One update per cycle.
- EMIT: index i runs from 1 to MAX_LABEL-1.
  - Entry with area=0: skipped in one cycle with `stat_valid`=0.
  - Entry with area>0: present a record with `stat_valid`=1. Hold all stat_* stable until `stat_valid && stat_ready`, then advance i.
  - After the last index is handled, go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Area arithmetic: 11 bits, no saturation needed (max 1024).
- `start` outside IDLE is ignored. `start` held high causes a new run immediately after DONE→IDLE.
- Reset mid-run: return to IDLE immediately with every output at its reset value. Table contents are don't-care, since the next run clears them.

## Timing
- Reset values: `sram_a`=0, `busy`=0, `stat_valid`=0, all stat_* = 0, `ovf`=0, `done`=0.
- `sram_a` is registered; it holds 0 outside SCAN.
- Read latency is a fixed 1 cycle; no SRAM write enable is driven.
- With `stat_ready` tied high and MAX_LABEL=64:
  - `done` is high exactly 1153 cycles after the edge that samples `start` (64 + 1025 + 63 + 1).
  - The total is independent of image content.
- Each cycle of `stat_ready`=0 while `stat_valid`=1 adds exactly one cycle.
- `stat_valid` never drops without a handshake. A new record may appear in the cycle after a handshake.

## Configuration
- `CLE_STAT_BBOX_EN` defined: bounding box is tracked in the table and output on stat_x*/stat_y*.
- `CLE_STAT_BBOX_EN` undefined:
  - No bbox storage is built.
  - stat_xmin/xmax/ymin/ymax are tied to 0.
  - Area, `ovf`, ordering and cycle counts are unchanged.

## Test plan
- All-zero image, ready=1 → no `stat_valid`; `done` 1153 cycles after `start`; `ovf`=0.
- Single pixel of label 1 at address 0xA3 (x=3, y=5) → one record: label=1, area=1, x 3..3, y 5..5.
- Two labels: label 2 as a 4x3 rectangle at (10..13, 0..2) and label 7 covering the full row y=31 → records in order: label 2 (area 12, x 10..13, y 0..2), then label 7 (area 32, x 0..31, y 31..31).
- Backpressure: same image as the two-label test, `stat_ready`=0 for 10 cycles while label 2 is presented → outputs stay stable, no record is lost or duplicated, `done` is delayed by exactly 10 cycles.
- Label 70 written at one pixel with MAX_LABEL=64 → `ovf`=1 through DONE; no record for label 70; `ovf` is cleared at the next `start`.
- `reset` pulsed at SCAN address 500, then `start` again on the same image → all outputs at reset values during reset; the second run produces correct records.
